// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - round-robin sequencer sharing one 4-bit enabled up-counter between two requesters
module count_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] cnt_q,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tgt_q, tgt_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic [1:0] done_q, done_d;
    logic       busy_q, busy_d;

    logic       win_idx;
    logic       held;

    // Contested requests go to whoever was not served last.
    always_comb begin
        win_idx = 1'b0;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_q;
            default: win_idx = 1'b0;
        endcase
    end

    assign held = |(req & gnt_q);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = win_idx ? 2'b10 : 2'b01;
                    tgt_d   = win_idx ? len1 : len0;
                    last_d  = win_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (held) begin
                    state_d = RUN;
                end else begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!held) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end else if (cnt_q == tgt_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs other than cnt_en are decoded from the next state so they come straight off flops.
    always_comb begin
        cnt_clr_d = (state_d == CLEAR);
        done_d    = (state_d == DONE) ? gnt_d : 2'b00;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_q     <= 4'd0;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            cnt_clr_q <= 1'b0;
            done_q    <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Enable drops in the same cycle the grantee lets go, so an abort never over-counts.
    assign cnt_en  = (state_q == RUN) && held && (cnt_q != tgt_q);
    assign cnt_clr = cnt_clr_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - directed vector bench for count_arbiter with a behavioural 4-bit counter
module tb_count_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] len0 = 4'd0;
    logic [3:0] len1 = 4'd0;
    logic [3:0] cnt;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    count_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .cnt_q   (cnt),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)          cnt <= 4'd0;
        else if (cnt_clr) cnt <= 4'd0;
        else if (cnt_en)  cnt <= cnt + 4'd1;
    end

    typedef struct packed {
        logic [1:0] req;
        logic [3:0] len0;
        logic [3:0] len1;
        logic [1:0] gnt;
        logic [1:0] done;
        logic       en;
        logic       clr;
        logic       busy;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int         n_done, n_clr, en_cycles;
    int         done_cyc [4];
    logic [1:0] done_val [4];
    logic [1:0] clr_gnt  [4];
    logic [3:0] cnt_at17;

    initial begin
        //            req    len0   len1   gnt    done  en    clr   busy  cnt
        tbl[0]  = '{2'b01, 4'd5, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{2'b01, 4'd5, 4'd0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[2]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 4'd0};
        tbl[3]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 4'd1};
        tbl[4]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 4'd2};
        tbl[5]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 4'd3};
        tbl[6]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 4'd4};
        tbl[7]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 4'd5};
        tbl[8]  = '{2'b01, 4'd2, 4'd0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 4'd5};
        tbl[9]  = '{2'b00, 4'd2, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd5};
        tbl[10] = '{2'b10, 4'd7, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd5};
        tbl[11] = '{2'b10, 4'd7, 4'd0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 4'd5};
        tbl[12] = '{2'b10, 4'd7, 4'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[13] = '{2'b10, 4'd7, 4'd0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[14] = '{2'b00, 4'd7, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[15] = '{2'b00, 4'd7, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0};

        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", {9'd0, gnt, done, cnt_en, cnt_clr, busy}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // Single run of 5 with a len change mid-run, then a zero-length run.
        for (int i = 0; i < 16; i++) begin
            req  = tbl[i].req;
            len0 = tbl[i].len0;
            len1 = tbl[i].len1;
            @(negedge clk);
            check($sformatf("table_row%0d", i),
                  {5'd0, gnt, done, cnt_en, cnt_clr, busy, cnt},
                  {5'd0, tbl[i].gnt, tbl[i].done, tbl[i].en, tbl[i].clr, tbl[i].busy, tbl[i].cnt});
            next_cycle();
        end

        // Round-robin with both requests held.
        req = 2'b11; len0 = 4'd2; len1 = 4'd3;
        n_done = 0; n_clr = 0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (cnt_clr && n_clr < 4) begin
                clr_gnt[n_clr] = gnt;
                n_clr++;
            end
            if (done != 2'b00 && n_done < 4) begin
                done_cyc[n_done] = c;
                done_val[n_done] = done;
                n_done++;
            end
            next_cycle();
        end
        req = 2'b00;
        check("rr_done_count", 16'(n_done), 16'd3);
        check("rr_clear_count", 16'(n_clr), 16'd3);
        if (n_done == 3) begin
            check("rr_done0_cycle", 16'(done_cyc[0]), 16'd5);
            check("rr_done1_cycle", 16'(done_cyc[1]), 16'd12);
            check("rr_done2_cycle", 16'(done_cyc[2]), 16'd18);
            check("rr_done_order", {10'd0, done_val[0], done_val[1], done_val[2]}, {10'd0, 6'b01_10_01});
        end
        if (n_clr == 3)
            check("rr_grant_order", {10'd0, clr_gnt[0], clr_gnt[1], clr_gnt[2]}, {10'd0, 6'b01_10_01});

        // Maximum length: 15 enables, counter parks at 15.
        next_cycle();
        req = 2'b01; len0 = 4'd15;
        en_cycles = 0; n_done = 0; cnt_at17 = 4'd0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (cnt_en) en_cycles++;
            if (c == 17) cnt_at17 = cnt;
            if (done != 2'b00) begin
                n_done++;
                if (c == 18) done_val[0] = done;
            end
            next_cycle();
        end
        req = 2'b00;
        check("max_en_cycles", 16'(en_cycles), 16'd15);
        check("max_cnt_at_tgt", {12'd0, cnt_at17}, 16'd15);
        check("max_done_once", 16'(n_done), 16'd1);
        check("max_done_value", {14'd0, done_val[0]}, 16'd1);
        next_cycle();
        @(negedge clk);
        check("max_no_wrap", {11'd0, busy, cnt}, {11'd0, 1'b0, 4'd15});
        next_cycle();

        // Abort: requester 0 drops in its third RUN cycle while requester 1 waits.
        n_done = 0;
        len0 = 4'd9; len1 = 4'd1;
        for (int c = 0; c < 12; c++) begin
            case (c)
                0:  req = 2'b01;
                1:  req = 2'b11;
                4:  req = 2'b10;
                10: req = 2'b00;
                default: ;
            endcase
            @(negedge clk);
            if (c < 9 && done != 2'b00) n_done++;
            case (c)
                3:  check("abort_running", {11'd0, cnt_en, cnt}, {11'd0, 1'b1, 4'd1});
                5:  check("abort_idle", {12'd0, gnt, cnt_en, busy}, 16'd0);
                6:  check("abort_next_grant", {13'd0, gnt, cnt_clr}, {13'd0, 2'b10, 1'b1});
                9:  check("abort_next_done", {14'd0, done}, {14'd0, 2'b10});
                11: check("abort_final_idle", {15'd0, busy}, 16'd0);
                default: ;
            endcase
            next_cycle();
        end
        check("abort_no_done", 16'(n_done), 16'd0);

        // Reset in the middle of a run, then requester 0 must win the first tie.
        req = 2'b01; len0 = 4'd9;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) check("rst_pre_enable", {15'd0, cnt_en}, 16'd1);
            if (c < 3) next_cycle();
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_drop", {9'd0, gnt, done, cnt_en, cnt_clr, busy}, 16'd0);
        req = 2'b11; len0 = 4'd1; len1 = 4'd1;
        @(negedge clk);
        check("rst_held", {9'd0, gnt, done, cnt_en, cnt_clr, busy}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_first_grant", {13'd0, gnt, cnt_clr}, {13'd0, 2'b01, 1'b1});
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("final_idle", {12'd0, gnt, busy, cnt_en}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
